// File: rtl/reshape_frame_sched.sv
// reshape_frame_sched
//
// Frame-level scheduler for the flow-reshape remap datapath. Two ping-pong source
// buffers are shared between the frame loader (writes buffer wp) and the reshaper
// (reads buffer rp). Once a source buffer is full and the single output buffer is
// free, the scheduler pulses rs_ena for one cycle and counts reshaper write strobes
// until a whole output frame has been written. The output buffer is then held
// (out_valid) until the consumer acknowledges it. A watchdog bounds each pass.
//
// Ports:
//   clk, rst     single clock; synchronous active-high reset
//   ld_done      loader pulse: buffer ld_sel fully written
//   ld_sel       buffer the loader must write next
//   ld_ready     buffer ld_sel is free
//   ld_overrun   sticky: ld_done arrived while ld_ready was low
//   rs_ena       one-cycle reshaper start pulse
//   rs_sel       buffer the reshaper reads
//   rs_wr_en     reshaper output write strobe (one per output pixel)
//   busy         a reshape pass is starting or running
//   out_valid    output buffer holds a complete frame
//   out_ack      consumer pulse: output buffer drained
//   err_timeout  sticky watchdog fault
//   frames_done  completed-frame count, wraps at 2^16

module reshape_frame_sched #(
  parameter int unsigned OUT_PIXELS = 67600,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned TIMEOUT    = 300000,
  parameter int unsigned TO_W       = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_done,
  output logic        ld_sel,
  output logic        ld_ready,
  output logic        ld_overrun,
  output logic        rs_ena,
  output logic        rs_sel,
  input  logic        rs_wr_en,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ack,
  output logic        err_timeout,
  output logic [15:0] frames_done
);

  localparam logic [CNT_W-1:0] PixLast = CNT_W'(OUT_PIXELS - 1);
  localparam logic [CNT_W-1:0] PixOne  = CNT_W'(1);
  localparam logic [TO_W-1:0]  WdLast  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  WdOne   = TO_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StWaitOut,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [TO_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             ld_overrun_q, ld_overrun_d;
  logic             err_timeout_q, err_timeout_d;
  logic [15:0]      frames_done_q, frames_done_d;

  logic ld_ready_w;
  logic frame_done_w;

  assign ld_ready_w   = ~full_q[wp_q];
  // Last pixel strobe of the pass; only meaningful while running.
  assign frame_done_w = (state_q == StRun) && rs_wr_en && (pix_cnt_q == PixLast);

  always_comb begin
    state_d       = state_q;
    full_d        = full_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    pix_cnt_d     = pix_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    out_valid_d   = out_valid_q;
    ld_overrun_d  = ld_overrun_q;
    err_timeout_d = err_timeout_q;
    frames_done_d = frames_done_q;

    // Loader handshake runs in every state, including HALT.
    if (ld_done) begin
      if (ld_ready_w) begin
        full_d[wp_q] = 1'b1;
        wp_d         = ~wp_q;
      end else begin
        ld_overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (full_q[rp_q] && !out_valid_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        pix_cnt_d = '0;
        wd_cnt_d  = '0;
        state_d   = StRun;
      end

      StRun: begin
        // Both counters saturate so neither can wrap.
        if (rs_wr_en && (pix_cnt_q != PixLast)) begin
          pix_cnt_d = pix_cnt_q + PixOne;
        end
        if (wd_cnt_q != WdLast) begin
          wd_cnt_d = wd_cnt_q + WdOne;
        end
        // Completion takes priority over a coincident watchdog expiry.
        if (frame_done_w) begin
          full_d[rp_q]  = 1'b0;
          rp_d          = ~rp_q;
          out_valid_d   = 1'b1;
          frames_done_d = frames_done_q + 16'd1;
          state_d       = StWaitOut;
        end else if (wd_cnt_q == WdLast) begin
          err_timeout_d = 1'b1;
          state_d       = StHalt;
        end
      end

      StWaitOut: begin
        if (out_ack) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      full_q        <= 2'b00;
      wp_q          <= 1'b0;
      rp_q          <= 1'b0;
      pix_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      out_valid_q   <= 1'b0;
      ld_overrun_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      frames_done_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      pix_cnt_q     <= pix_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      out_valid_q   <= out_valid_d;
      ld_overrun_q  <= ld_overrun_d;
      err_timeout_q <= err_timeout_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign ld_sel      = wp_q;
  assign ld_ready    = ld_ready_w;
  assign ld_overrun  = ld_overrun_q;
  assign rs_ena      = (state_q == StStart);
  assign rs_sel      = rp_q;
  assign busy        = (state_q == StStart) || (state_q == StRun);
  assign out_valid   = out_valid_q;
  assign err_timeout = err_timeout_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_reshape_frame_sched.sv
// Directed bench for reshape_frame_sched with OUT_PIXELS=4, TIMEOUT=40.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_reshape_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_done = 1'b0;
  logic        ld_sel;
  logic        ld_ready;
  logic        ld_overrun;
  logic        rs_ena;
  logic        rs_sel;
  logic        rs_wr_en = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ack = 1'b0;
  logic        err_timeout;
  logic [15:0] frames_done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  reshape_frame_sched #(
    .OUT_PIXELS(4),
    .CNT_W     (3),
    .TIMEOUT   (40),
    .TO_W      (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_done    (ld_done),
    .ld_sel     (ld_sel),
    .ld_ready   (ld_ready),
    .ld_overrun (ld_overrun),
    .rs_ena     (rs_ena),
    .rs_sel     (rs_sel),
    .rs_wr_en   (rs_wr_en),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .err_timeout(err_timeout),
    .frames_done(frames_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld_done = 1'b0;
    rs_wr_en = 1'b0;
    out_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] obs;
    rst = 1'b1;
    tick();
    obs = {ld_sel, ld_ready, ld_overrun, rs_ena, rs_sel, busy, out_valid, err_timeout,
           frames_done, 1'b0};
    tests_run++;
    if (obs !== 25'b0100_0000_0000_0000_0000_0000_0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b required %b", obs, 25'b0100_0000_0000_0000_0000_0000_0);
    end
    rst = 1'b0;
  endtask

  // Single frame through buffer 0, strobes 4 cycles apart.
  task automatic test_single_frame();
    int ena_seen;
    do_reset();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tests_run++;
    if (ld_sel !== 1'b1 || ld_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ld_sel got sel=%b rdy=%b required sel=1 rdy=1", ld_sel, ld_ready);
    end
    tick();
    tests_run++;
    if (rs_ena !== 1'b1 || rs_sel !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_start got ena=%b sel=%b busy=%b required 1 0 1", rs_ena, rs_sel, busy);
    end
    tick();
    tests_run++;
    if (rs_ena !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ena_width got ena=%b busy=%b required 0 1", rs_ena, busy);
    end
    for (int i = 0; i < 4; i++) begin
      rs_wr_en = 1'b1;
      tick();
      rs_wr_en = 1'b0;
      if (i < 3) begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL single_early_valid strobe %0d got %b required 0", i, out_valid);
        end
        tick();
        tick();
        tick();
      end
    end
    tests_run++;
    if (out_valid !== 1'b1 || frames_done !== 16'd1 || busy !== 1'b0 || rs_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_complete got valid=%b frames=%0d busy=%b sel=%b required 1 1 0 1",
               out_valid, frames_done, busy, rs_sel);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || ld_ready !== 1'b1 || ld_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ack got valid=%b rdy=%b sel=%b required 0 1 1",
               out_valid, ld_ready, ld_sel);
    end
    ena_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rs_ena === 1'b1) ena_seen++;
    end
    tests_run++;
    if (ena_seen !== 0) begin
      tests_failed++;
      $display("FAIL single_idle_empty got %0d starts required 0", ena_seen);
    end
  endtask

  task automatic test_ping_pong();
    do_reset();
    ld_done = 1'b1;
    tick();
    tests_run++;
    if (ld_sel !== 1'b1 || ld_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pp_first_load got sel=%b rdy=%b required 1 1", ld_sel, ld_ready);
    end
    tick();
    tests_run++;
    if (ld_sel !== 1'b0 || ld_ready !== 1'b0 || rs_ena !== 1'b1 || rs_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL pp_second_load got sel=%b rdy=%b ena=%b rsel=%b required 0 0 1 0",
               ld_sel, ld_ready, rs_ena, rs_sel);
    end
    tick();
    ld_done = 1'b0;
    tests_run++;
    if (ld_overrun !== 1'b1 || ld_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL pp_overrun got ovr=%b sel=%b required 1 0", ld_overrun, ld_sel);
    end
    rs_wr_en = 1'b1;
    repeat (4) tick();
    rs_wr_en = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || rs_sel !== 1'b1 || ld_ready !== 1'b1 || frames_done !== 16'd1) begin
      tests_failed++;
      $display("FAIL pp_frame0 got valid=%b rsel=%b rdy=%b frames=%0d required 1 1 1 1",
               out_valid, rs_sel, ld_ready, frames_done);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    tests_run++;
    if (rs_ena !== 1'b1 || rs_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL pp_start1 got ena=%b rsel=%b required 1 1", rs_ena, rs_sel);
    end
    tick();
    rs_wr_en = 1'b1;
    repeat (4) tick();
    rs_wr_en = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || frames_done !== 16'd2 || rs_sel !== 1'b0 || ld_overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL pp_frame1 got valid=%b frames=%0d rsel=%b ovr=%b required 1 2 0 1",
               out_valid, frames_done, rs_sel, ld_overrun);
    end
  endtask

  task automatic test_backpressure();
    int ena_seen;
    int valid_lost;
    do_reset();
    ld_done = 1'b1;
    tick();
    tick();
    ld_done = 1'b0;
    tick();
    rs_wr_en = 1'b1;
    repeat (4) tick();
    rs_wr_en = 1'b0;
    ena_seen = 0;
    valid_lost = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rs_ena === 1'b1) ena_seen++;
      if (out_valid !== 1'b1) valid_lost++;
    end
    tests_run++;
    if (ena_seen !== 0 || valid_lost !== 0) begin
      tests_failed++;
      $display("FAIL bp_hold got starts=%0d dropped=%0d required 0 0", ena_seen, valid_lost);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tests_run++;
    if (rs_ena !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ack_plus1 got ena=%b valid=%b required 0 0", rs_ena, out_valid);
    end
    tick();
    tests_run++;
    if (rs_ena !== 1'b1 || rs_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ack_plus2 got ena=%b rsel=%b required 1 1", rs_ena, rs_sel);
    end
  endtask

  // Strobes outside their state must leave counters and flags alone.
  task automatic test_stray_strobes();
    do_reset();
    rs_wr_en = 1'b1;
    out_ack = 1'b1;
    repeat (3) tick();
    rs_wr_en = 1'b0;
    out_ack = 1'b0;
    tests_run++;
    if (frames_done !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_idle got frames=%0d valid=%b busy=%b required 0 0 0",
               frames_done, out_valid, busy);
    end
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tick();
    tick();
    out_ack = 1'b1;
    rs_wr_en = 1'b1;
    repeat (3) tick();
    out_ack = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_three_strobes got valid=%b required 0", out_valid);
    end
    tick();
    rs_wr_en = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || frames_done !== 16'd1) begin
      tests_failed++;
      $display("FAIL stray_ack_in_run got valid=%b frames=%0d required 1 1", out_valid, frames_done);
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    int early;
    int ena_seen;
    do_reset();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tick();
    tick();
    cyc = 0;
    rs_wr_en = 1'b1;
    tick();
    tick();
    cyc = 2;
    rs_wr_en = 1'b0;
    early = 0;
    while (cyc < 39) begin
      tick();
      cyc++;
      if (err_timeout !== 1'b0) early++;
    end
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("FAIL wd_early got %0d early cycles required 0", early);
    end
    tick();
    tests_run++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_expire got err=%b busy=%b valid=%b required 1 0 0",
               err_timeout, busy, out_valid);
    end
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    rs_wr_en = 1'b1;
    out_ack = 1'b1;
    ena_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rs_ena === 1'b1) ena_seen++;
    end
    rs_wr_en = 1'b0;
    out_ack = 1'b0;
    tests_run++;
    if (ena_seen !== 0 || ld_sel !== 1'b0 || ld_ready !== 1'b0 || rs_sel !== 1'b0 ||
        err_timeout !== 1'b1 || frames_done !== 16'd0) begin
      tests_failed++;
      $display("FAIL wd_halt got starts=%0d sel=%b rdy=%b rsel=%b err=%b frames=%0d required 0 0 0 0 1 0",
               ena_seen, ld_sel, ld_ready, rs_sel, err_timeout, frames_done);
    end
  endtask

  task automatic test_collision_and_reset();
    int cyc;
    logic [24:0] obs;
    do_reset();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tick();
    tick();
    rs_wr_en = 1'b1;
    repeat (3) tick();
    rs_wr_en = 1'b0;
    cyc = 3;
    while (cyc < 39) begin
      tick();
      cyc++;
    end
    // Last strobe lands in the watchdog's final cycle; a load on the other buffer too.
    rs_wr_en = 1'b1;
    ld_done = 1'b1;
    tick();
    rs_wr_en = 1'b0;
    ld_done = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || err_timeout !== 1'b0 || frames_done !== 16'd1) begin
      tests_failed++;
      $display("FAIL coll_completion got valid=%b err=%b frames=%0d required 1 0 1",
               out_valid, err_timeout, frames_done);
    end
    tests_run++;
    if (ld_sel !== 1'b0 || ld_ready !== 1'b1 || ld_overrun !== 1'b0 || rs_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL coll_diff_buf got sel=%b rdy=%b ovr=%b rsel=%b required 0 1 0 1",
               ld_sel, ld_ready, ld_overrun, rs_sel);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    tick();
    rs_wr_en = 1'b1;
    tick();
    rs_wr_en = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL coll_in_run got busy=%b required 1", busy);
    end
    rst = 1'b1;
    tick();
    obs = {ld_sel, ld_ready, ld_overrun, rs_ena, rs_sel, busy, out_valid, err_timeout,
           frames_done, 1'b0};
    rst = 1'b0;
    tests_run++;
    if (obs !== 25'b0100_0000_0000_0000_0000_0000_0) begin
      tests_failed++;
      $display("FAIL midrun_reset got %b required %b", obs, 25'b0100_0000_0000_0000_0000_0000_0);
    end
  endtask

  // Completion on buffer 0 while the loader offers buffer 0 again: ignored as overrun.
  task automatic test_same_buf_collision();
    do_reset();
    ld_done = 1'b1;
    tick();
    tick();
    ld_done = 1'b0;
    tick();
    rs_wr_en = 1'b1;
    repeat (3) tick();
    ld_done = 1'b1;
    tick();
    rs_wr_en = 1'b0;
    ld_done = 1'b0;
    tests_run++;
    if (ld_overrun !== 1'b1 || out_valid !== 1'b1 || ld_sel !== 1'b0 || ld_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_buf got ovr=%b valid=%b sel=%b rdy=%b required 1 1 0 1",
               ld_overrun, out_valid, ld_sel, ld_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ping_pong();
    test_backpressure();
    test_stray_strobes();
    test_watchdog();
    test_collision_and_reset();
    test_same_buf_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reshape_frame_sched.md
Name: reshape_frame_sched

Overview:
Frame-level scheduler for the flow-reshape remap datapath. It manages two ping-pong source frame buffers shared between the frame loader and the reshaper. It issues the one-cycle start pulse and the buffer select to the reshaper, and detects frame completion by counting reshaper write strobes. It then holds the single output buffer until the downstream consumer acknowledges it, and runs a watchdog on each reshape pass.

Parameters:
OUT_PIXELS, 67600, output pixels per frame (260x260); one rs_wr_en pulse per pixel
CNT_W, 17, width of the pixel counter; must satisfy 2^CNT_W > OUT_PIXELS
TIMEOUT, 300000, max cycles allowed in RUN before a watchdog fault (nominal pass is about 4*OUT_PIXELS+6 cycles)
TO_W, 19, width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
ld_done  in  1  loader pulse: buffer ld_sel fully written
ld_sel  out  1  source buffer the loader must write next
ld_ready  out  1  buffer ld_sel is free; loader may write it
ld_overrun  out  1  sticky: ld_done seen while ld_ready=0
rs_ena  out  1  one-cycle start pulse to the reshaper
rs_sel  out  1  source buffer the reshaper reads (drives the read-address MSB mux)
rs_wr_en  in  1  reshaper output write strobe
busy  out  1  state is START or RUN
out_valid  out  1  output buffer holds a complete frame
out_ack  in  1  consumer pulse: output buffer drained
err_timeout  out  1  sticky watchdog fault
frames_done  out  16  completed-frame count, wraps at 2^16

Behaviour:
- Synchronous reset: all of the following on the first clk edge with rst=1, regardless of state:
  - state=IDLE; full[1:0]=0; wp=0; rp=0
  - pixel and watchdog counters=0
  - all outputs 0, except ld_ready=1
- Loader side:
  - ld_sel=wp; ld_ready=~full[wp], from registered flags.
  - ld_done with ld_ready=1: set full[wp] and toggle wp next cycle.
  - ld_done with ld_ready=0: ignored and ld_overrun set. Only rst clears ld_overrun.
- State IDLE:
  - When full[rp]=1 and out_valid=0, go to START.
  - rs_sel follows rp at all times; it is stable for the whole pass.
- State START (1 cycle):
  - rs_ena=1; clear pixel and watchdog counters; go to RUN.
- State RUN:
  - Each rs_wr_en increments the pixel counter; the watchdog counter increments every cycle.
  - rs_wr_en with pixel counter at OUT_PIXELS-1 means frame complete. On the next cycle:
    - full[rp] cleared and rp toggled
    - out_valid=1
    - frames_done incremented
    - state=WAIT_OUT
  - Watchdog counter reaching TIMEOUT-1 with no completion: err_timeout=1, state=HALT.
  - If completion and timeout occur in the same cycle, completion wins.
- State WAIT_OUT:
  - Hold out_valid=1.
  - out_ack drops out_valid next cycle and returns to IDLE. A new START therefore follows out_ack by at least 2 cycles.
- State HALT:
  - Terminal: no further rs_ena; full/wp/rp frozen; the loader may still fill a free buffer.
  - Exit only via rst.
- Strobes outside their state are ignored, with no counter or flag change:
  - rs_wr_en outside RUN
  - out_ack outside WAIT_OUT
- Same-cycle cases:
  - ld_done and completion in the same cycle on the same buffer: ld_ready was 0, so ld_done is ignored and counts as an overrun.
  - On different buffers both updates apply.
- Bounds: neither counter may wrap.
  - The pixel counter never exceeds OUT_PIXELS-1.
  - The watchdog counter never exceeds TIMEOUT-1.

Test Plan:
1. OUT_PIXELS=4, TIMEOUT=40.
   - Stimulus: rst; ld_done; after rs_ena, four rs_wr_en pulses 4 cycles apart.
   - Required: rs_ena exactly 1 cycle with rs_sel=0; out_valid rises the cycle after the 4th strobe; frames_done=1.
   - Then out_ack → IDLE; full=00.
2. Ping-pong.
   - Stimulus: two ld_done pulses back-to-back.
   - Required: ld_sel 0→1, ld_ready drops to 0 after the second; the third ld_done sets ld_overrun=1.
   - Frames are processed with rs_sel=0 then rs_sel=1.
3. Backpressure.
   - Stimulus: hold out_ack=0 for 20 cycles with buffer 1 full.
   - Required: no rs_ena during WAIT_OUT; rs_ena occurs exactly 2 cycles after out_ack.
4. Watchdog.
   - Stimulus: after rs_ena, only 2 rs_wr_en pulses.
   - Required: err_timeout=1 exactly 40 cycles after RUN entry; no further rs_ena; full[0] stays 1.
5. Collision and mid-run reset.
   - Stimulus: completion and watchdog expiry in the same cycle, then rst asserted mid-RUN.
   - Required: completion wins with err_timeout=0; rst returns every output to its reset value on the next edge, with ld_ready=1.
